var_lat_checker: RTL and testbench

- Synthesizable multi-channel variable-latency response monitor. It replaces the bench-only local-variable assertion pattern used for variable delays.
- For each channel, a falling edge of `wr` opens a transaction and latches a runtime latency L and a read_data snapshot.
- Exactly L+1 cycles later, the block checks `exp_data == snapshot + OFFSET` and reports pass or fail.
- It sits beside the DUT in the verification harness, and can also sit in silicon as a self-check monitor.

---
 rtl/var_lat_checker.sv | 159 +++++++++++++++
 tb/tb_var_lat_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/var_lat_checker.sv
// Per-channel variable-latency response monitor: a wr fall latches latency L and a data snapshot, and the check fires L+1 edges later.
// Pulses are registered, so they appear one cycle after the check; there is no backpressure, and a restart abandons the pending check.
module var_lat_checker #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 8,
  parameter int OFFSET = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        wr,
  input  logic [NUM_CH*LAT_W-1:0]  lat_in,
  input  logic [NUM_CH*DATA_W-1:0] read_data,
  input  logic [NUM_CH*DATA_W-1:0] exp_data,
  input  logic                     clear,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        pass_pulse,
  output logic [NUM_CH-1:0]        fail_pulse,
  output logic [NUM_CH-1:0]        ovr_pulse,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     err_sticky
);

  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  typedef struct packed {
    state_e              st;
    logic [LAT_W-1:0]    lat_cnt;
    logic [DATA_W-1:0]   snap;
  } ch_t;

  ch_t               ch_q [NUM_CH];
  ch_t               ch_d [NUM_CH];
  logic [NUM_CH-1:0] wr_q;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] pass_q, pass_d;
  logic [NUM_CH-1:0] fail_q, fail_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              err_q, err_d;
  logic [SUM_W-1:0]  pass_sum, fail_sum;

  function automatic logic [PC_W-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int b = 0; b < NUM_CH; b++) begin
      n = n + PC_W'(v[b]);
    end
    return n;
  endfunction

  // wr_q tracks wr unconditionally; ch_en gates only the start decision.
  assign start = ch_en & wr_q & ~wr;

  always_comb begin
    pass_d = '0;
    fail_d = '0;
    ovr_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i] = ch_q[i];
      case (ch_q[i].st)
        IDLE: begin
          if (start[i]) begin
            ch_d[i].st      = COUNT;
            ch_d[i].lat_cnt = lat_in[i*LAT_W +: LAT_W];
            ch_d[i].snap    = read_data[i*DATA_W +: DATA_W];
          end
        end
        COUNT: begin
          // A restart wins even on the check edge, so the old check is dropped.
          if (start[i]) begin
            ch_d[i].lat_cnt = lat_in[i*LAT_W +: LAT_W];
            ch_d[i].snap    = read_data[i*DATA_W +: DATA_W];
            ovr_d[i]        = 1'b1;
          end else if (ch_q[i].lat_cnt == '0) begin
            ch_d[i].st = IDLE;
            if (exp_data[i*DATA_W +: DATA_W] == ch_q[i].snap + DATA_W'(OFFSET)) begin
              pass_d[i] = 1'b1;
            end else begin
              fail_d[i] = 1'b1;
            end
          end else begin
            ch_d[i].lat_cnt = ch_q[i].lat_cnt - LAT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    pass_sum   = SUM_W'(pass_cnt_q) + SUM_W'(popcnt(pass_q));
    fail_sum   = SUM_W'(fail_cnt_q) + SUM_W'(popcnt(fail_q));
    pass_cnt_d = (pass_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
    fail_cnt_d = (fail_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];
    err_d      = err_q | (|fail_q);
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ovr_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i].st      <= IDLE;
        ch_q[i].lat_cnt <= '0;
        ch_q[i].snap    <= '0;
      end
    end else begin
      wr_q   <= wr;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ovr_q  <= ovr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= ch_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (ch_q[i].st == COUNT);
    end
  end

  assign pass_pulse = pass_q;
  assign fail_pulse = fail_q;
  assign ovr_pulse  = ovr_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_var_lat_checker.sv
// Directed bench for var_lat_checker: a default instance plus a CNT_W=2 instance on shared stimulus for saturation and clear.
module tb_var_lat_checker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ch_en, wr;
  logic [31:0]  lat_in;
  logic [127:0] read_data, exp_data;
  logic         clear;
  logic [3:0]   busy, pass_pulse, fail_pulse, ovr_pulse;
  logic [15:0]  pass_cnt, fail_cnt;
  logic         err_sticky;
  logic [3:0]   s_busy, s_pass_pulse, s_fail_pulse, s_ovr_pulse;
  logic [1:0]   s_pass_cnt, s_fail_cnt;
  logic         s_err_sticky;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  var_lat_checker dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .wr(wr), .lat_in(lat_in),
    .read_data(read_data), .exp_data(exp_data), .clear(clear),
    .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse), .ovr_pulse(ovr_pulse),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky)
  );

  var_lat_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .wr(wr), .lat_in(lat_in),
    .read_data(read_data), .exp_data(exp_data), .clear(clear),
    .busy(s_busy), .pass_pulse(s_pass_pulse), .fail_pulse(s_fail_pulse), .ovr_pulse(s_ovr_pulse),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .err_sticky(s_err_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_en = 4'hF; wr = '0; clear = 1'b0;
    lat_in = '0; read_data = '0; exp_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_ch(input int ch, input logic [7:0] lat, input logic [31:0] rd, input logic [31:0] ex);
    lat_in[ch*8 +: 8]     = lat;
    read_data[ch*32 +: 32] = rd;
    exp_data[ch*32 +: 32]  = ex;
  endtask

  // Rise sampled on one edge, fall on the next: returns just after the start edge.
  task automatic start(input int ch);
    wr[ch] = 1'b1;
    tick();
    wr[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (busy !== 4'h0) begin fails++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    tests_run++; if ((pass_pulse | fail_pulse | ovr_pulse) !== 4'h0) begin fails++; $display("FAIL reset_pulses got=%b exp=0000", pass_pulse | fail_pulse | ovr_pulse); end
    tests_run++; if ({pass_cnt, fail_cnt} !== 32'd0) begin fails++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
    tests_run++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
  endtask

  task automatic test_basic_pass();
    do_reset();
    set_ch(0, 8'd5, 32'd40, 32'd50);
    start(0);
    for (int j = 0; j < 6; j++) begin
      tests_run++; if (busy[0] !== 1'b1 || pass_pulse[0] !== 1'b0) begin fails++; $display("FAIL pass_busy_win j=%0d got busy=%b pp=%b exp busy=1 pp=0", j, busy[0], pass_pulse[0]); end
      tick();
    end
    tests_run++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL pass_busy_end got=%b exp=0", busy[0]); end
    tests_run++; if (pass_pulse !== 4'b0001 || fail_pulse !== 4'h0) begin fails++; $display("FAIL pass_pulse got=%b/%b exp=0001/0000", pass_pulse, fail_pulse); end
    tick();
    tests_run++; if (pass_pulse !== 4'h0) begin fails++; $display("FAIL pass_pulse_len got=%b exp=0000", pass_pulse); end
    tests_run++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || err_sticky !== 1'b0) begin fails++; $display("FAIL pass_cnt got=%0d/%0d/%b exp=1/0/0", pass_cnt, fail_cnt, err_sticky); end
  endtask

  task automatic test_zero_lat_fail();
    do_reset();
    set_ch(1, 8'd0, 32'd7, 32'd18);
    start(1);
    tests_run++; if (busy !== 4'b0010) begin fails++; $display("FAIL l0_busy got=%b exp=0010", busy); end
    tick();
    tests_run++; if (fail_pulse !== 4'b0010 || pass_pulse !== 4'h0 || busy !== 4'h0) begin fails++; $display("FAIL l0_fail got fp=%b pp=%b busy=%b exp 0010/0000/0000", fail_pulse, pass_pulse, busy); end
    tick();
    tests_run++; if (fail_cnt !== 16'd1 || err_sticky !== 1'b1 || pass_cnt !== 16'd0) begin fails++; $display("FAIL l0_cnt got=%0d/%b/%0d exp=1/1/0", fail_cnt, err_sticky, pass_cnt); end
  endtask

  task automatic test_restart();
    int ovr_seen;
    do_reset();
    set_ch(2, 8'd10, 32'd1, 32'd100);
    start(2);
    tick(); tick();
    set_ch(2, 8'd3, 32'd90, 32'd100);
    start(2);
    tests_run++; if (ovr_pulse !== 4'b0100 || busy[2] !== 1'b1) begin fails++; $display("FAIL rst_ovr got=%b busy=%b exp=0100 busy=1", ovr_pulse, busy[2]); end
    ovr_seen = 0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      if (ovr_pulse[2]) ovr_seen++;
      tests_run++; if (pass_pulse[2] !== 1'b0) begin fails++; $display("FAIL rst_early j=%0d got=%b exp=0", j, pass_pulse[2]); end
    end
    tick();
    tests_run++; if (pass_pulse !== 4'b0100) begin fails++; $display("FAIL rst_pass got=%b exp=0100", pass_pulse); end
    tests_run++; if (ovr_seen !== 0) begin fails++; $display("FAIL rst_ovr_len got=%0d exp=0", ovr_seen); end
    repeat (10) tick();
    tests_run++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got=%0d/%0d exp=1/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_restart_on_check();
    do_reset();
    set_ch(3, 8'd2, 32'd5, 32'd15);
    start(3);
    tick();
    set_ch(3, 8'd1, 32'd5, 32'd15);
    start(3);
    tests_run++; if (ovr_pulse !== 4'b1000 || (pass_pulse | fail_pulse) !== 4'h0) begin fails++; $display("FAIL roc_drop got ovr=%b pf=%b exp 1000/0000", ovr_pulse, pass_pulse | fail_pulse); end
    tick(); tick();
    tests_run++; if (pass_pulse !== 4'b1000) begin fails++; $display("FAIL roc_pass got=%b exp=1000", pass_pulse); end
    tick();
    tests_run++; if (pass_cnt !== 16'd1) begin fails++; $display("FAIL roc_cnt got=%0d exp=1", pass_cnt); end
  endtask

  task automatic test_ch_en();
    do_reset();
    ch_en = 4'b1110;
    set_ch(0, 8'd2, 32'd1, 32'd11);
    start(0);
    tests_run++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL en_gate got=%b exp=0", busy[0]); end
    ch_en = 4'hF;
    tick();
    tests_run++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL en_late got=%b exp=0", busy[0]); end
    start(0);
    ch_en = 4'h0;
    tests_run++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL en_start got=%b exp=1", busy[0]); end
    tick(); tick(); tick();
    tests_run++; if (pass_pulse !== 4'b0001) begin fails++; $display("FAIL en_complete got=%b exp=0001", pass_pulse); end
  endtask

  task automatic test_all_channels();
    do_reset();
    set_ch(0, 8'd2, 32'd0, 32'd10);
    set_ch(1, 8'd2, 32'd1000, 32'd1010);
    set_ch(2, 8'd2, 32'hDEAD_0000, 32'hDEAD_000A);
    set_ch(3, 8'd2, 32'hFFFF_FFFA, 32'd4);
    wr = 4'hF; tick();
    wr = 4'h0; tick();
    tick(); tick(); tick();
    tests_run++; if (pass_pulse !== 4'hF || fail_pulse !== 4'h0) begin fails++; $display("FAIL all_pulse got=%b/%b exp=1111/0000", pass_pulse, fail_pulse); end
    tests_run++; if (pass_cnt !== 16'd0) begin fails++; $display("FAIL all_cnt_pre got=%0d exp=0", pass_cnt); end
    tick();
    tests_run++; if (pass_cnt !== 16'd4) begin fails++; $display("FAIL all_cnt got=%0d exp=4", pass_cnt); end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    set_ch(0, 8'd0, 32'd0, 32'd10);
    repeat (5) begin start(0); tick(); end
    tick(); tick();
    tests_run++; if (s_pass_cnt !== 2'd3) begin fails++; $display("FAIL sat_cnt got=%0d exp=3", s_pass_cnt); end
    tests_run++; if (pass_cnt !== 16'd5) begin fails++; $display("FAIL sat_wide got=%0d exp=5", pass_cnt); end
    set_ch(1, 8'd0, 32'd0, 32'd99);
    start(1); tick(); tick();
    tests_run++; if (s_fail_cnt !== 2'd1 || s_err_sticky !== 1'b1) begin fails++; $display("FAIL sat_fail got=%0d/%b exp=1/1", s_fail_cnt, s_err_sticky); end
    clear = 1'b1; tick(); clear = 1'b0;
    tests_run++; if (s_pass_cnt !== 2'd0 || s_fail_cnt !== 2'd0 || s_err_sticky !== 1'b0) begin fails++; $display("FAIL clr got=%0d/%0d/%b exp=0/0/0", s_pass_cnt, s_fail_cnt, s_err_sticky); end
    wr = 4'b0011; tick();
    wr = 4'b0000; tick();
    tick();
    tests_run++; if (pass_pulse !== 4'b0001 || fail_pulse !== 4'b0010) begin fails++; $display("FAIL clr_pulses got=%b/%b exp=0001/0010", pass_pulse, fail_pulse); end
    clear = 1'b1; tick(); clear = 1'b0;
    tick();
    tests_run++; if (s_pass_cnt !== 2'd0 || s_fail_cnt !== 2'd0 || s_err_sticky !== 1'b0 || err_sticky !== 1'b0) begin fails++; $display("FAIL clr_wins got=%0d/%0d/%b/%b exp=0/0/0/0", s_pass_cnt, s_fail_cnt, s_err_sticky, err_sticky); end
  endtask

  task automatic test_async_reset();
    int activity;
    do_reset();
    set_ch(0, 8'd20, 32'd3, 32'd13);
    start(0);
    repeat (7) tick();
    wr[0] = 1'b1;
    tick();
    tests_run++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL ar_pre got=%b exp=1", busy[0]); end
    #2;
    rst_n = 1'b0;
    wr = '0;
    #1;
    tests_run++; if (busy !== 4'h0) begin fails++; $display("FAIL ar_busy got=%b exp=0000", busy); end
    tick();
    rst_n = 1'b1;
    activity = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if ((busy | pass_pulse | fail_pulse | ovr_pulse) != 4'h0) activity++;
    end
    tests_run++; if (activity !== 0) begin fails++; $display("FAIL ar_quiet got=%0d active cycles exp=0", activity); end
    tests_run++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin fails++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_pass();
    test_zero_lat_fail();
    test_restart();
    test_restart_on_check();
    test_ch_en();
    test_all_channels();
    test_saturate_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
